data_mem_unit: RTL and testbench
================================

# data_mem_unit

Multi-cycle data memory responder serving the MEM stage of the pipelined MIPS core. It accepts one load or store request at a time from the MEM stage (`MEM_R_EN` / `MEM_W_EN`, address, store data). It holds the pipeline with `freeze` for a programmable latency, then returns `ready` together with the load data. `Mem_read_value` is then captured by the MEM stage register.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words in the array.
- `BASE_ADDR`, 1024: byte address that maps to word 0.
- `LATENCY`, 2: cycles from request acceptance to `ready`; legal range 1..15.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `MEM_R_EN`  in  1  load request, level.
- `MEM_W_EN`  in  1  store request, level.
- `addr`  in  32  byte address (ALU result).
- `write_data`  in  32  store data.
- `read_data`  out  32  load data, valid while `ready`=1.
- `ready`  out  1  one-cycle completion pulse.
- `freeze`  out  1  stall request to the hazard/freeze logic.
- `addr_err`  out  1  only with `DATA_MEM_ALIGN_CHECK_EN`; see Configuration.

## Operation
- Word index = (`addr` − `BASE_ADDR`) >> 2, 32-bit unsigned subtraction. `addr` < `BASE_ADDR` wraps to a large index and is therefore out of range.
- Index ≥ `DEPTH_WORDS` is out of range: the store is dropped and the load returns 32'h0.
- FSM states:
  - IDLE: if `MEM_R_EN` or `MEM_W_EN` = 1, latch op, index, `write_data`, and go to WAIT. If LATENCY=1, go directly to DONE.
  - WAIT: the down-counter is loaded with LATENCY−1 on accept and decrements each cycle. Go to DONE when it reaches 1.
  - DONE: `ready`=1 for exactly one cycle, then IDLE unconditionally. Enables are not sampled in DONE, so the still-asserted request is not re-accepted.
- Store commits to the array on the clock edge entering DONE. A load reads the array on that same edge into `read_data`.
- `MEM_R_EN` and `MEM_W_EN` both high: the request is treated as a store, and `read_data` returns the stored value.
- `freeze` = (IDLE & (`MEM_R_EN` | `MEM_W_EN`)) | WAIT. It is combinational and deasserted in DONE, so the pipeline advances on the `ready` cycle.
- Request inputs change while in WAIT: they are ignored, because the latched copy is used.
- `read_data` holds its last value outside DONE; the bench checks it only while `ready`=1.

## Timing
- Reset values: state IDLE, counter 0, `ready`=0, `read_data`=32'h0, `addr_err`=0. Array contents are not reset.
- `freeze` is combinational, so with no request pending it is 0 during reset.
- A request is accepted at edge T when it is present in IDLE. `ready`=1 in cycle T+LATENCY. The earliest next accept is T+LATENCY+1, so the throughput is one request per LATENCY+1 cycles.
- Reset mid-operation: an uncommitted store is discarded, the FSM returns to IDLE and no `ready` pulse is produced. The array keeps the words already written.

## Configuration
- `DATA_MEM_ALIGN_CHECK_EN` defined:
  - Port `addr_err` exists.
  - A request with `addr[1:0]` ≠ 0 or an out-of-range index still completes with normal latency, but the store is dropped and the load returns 32'h0.
  - `addr_err`=1 in the same cycle as `ready`, otherwise 0.
- Not defined: there is no `addr_err` port, `addr[1:0]` is ignored (truncated), and out-of-range requests behave as in Operation.

## Test plan
- Reset, then store `addr`=1028 data 32'hDEADBEEF, LATENCY=2:
  - `freeze`=1 in cycles T and T+1, `ready`=1 in T+2.
  - A following load from 1028 returns 32'hDEADBEEF with `ready`.
- LATENCY=1 back-to-back load, store, load to `addr`=1024:
  - Each `ready` arrives one cycle after accept, and accepts are spaced 2 cycles.
  - The second load returns the stored value.
- `MEM_R_EN`=`MEM_W_EN`=1, `addr`=1032, data 32'h12345678: `read_data`=32'h12345678 with `ready`, and a later load confirms the write.
- Out-of-range and misaligned accesses:
  - Load from `addr`=0 (wraps) and store to 1024+4·DEPTH_WORDS: `read_data`=0, no array change.
  - With the macro defined, `addr`=1026 raises `addr_err` with `ready`.
- Assert `rst`=0 during WAIT of a store to 1036 (32'hCAFEF00D):
  - No `ready`, outputs at reset values.
  - After release, a load from 1036 returns the prior contents.
- Hold the request stable through `freeze` while the bench changes `write_data` during WAIT: the originally latched value is stored.

Source files
------------

// File: rtl/data_mem_unit.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_unit
// Purpose  : Multi-cycle data memory responder for the MEM stage; stalls the
//            pipeline with freeze for LATENCY cycles, then pulses ready.
// Option   : DATA_MEM_ALIGN_CHECK_EN adds addr_err and rejects misaligned
//            or out-of-range requests.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_unit #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        freeze
`ifdef DATA_MEM_ALIGN_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] C_DEPTH  = 32'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic             ok_q, ok_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             w_req;
  logic [31:0]      w_offset;
  logic [29:0]      w_word_idx;
  logic             w_ok;
  logic             w_unused_lsbs;
  logic             w_commit;
  logic             c_we;
  logic             c_ok;
  logic [IDX_W-1:0] c_idx;
  logic [31:0]      c_wdata;

  assign w_req         = MEM_R_EN | MEM_W_EN;
  assign w_offset      = addr - BASE_ADDR;
  assign w_word_idx    = w_offset[31:2];
  assign w_unused_lsbs = ^w_offset[1:0];

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign w_ok = ({2'b00, w_word_idx} < C_DEPTH) && (addr[1:0] == 2'b00);
`else
  assign w_ok = ({2'b00, w_word_idx} < C_DEPTH);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    ok_d    = ok_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          // A simultaneous read+write is a store; read_data then echoes it.
          we_d    = MEM_W_EN;
          ok_d    = w_ok;
          idx_d   = w_word_idx[IDX_W-1:0];
          wdata_d = write_data;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY <= 1) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        if (cnt_q <= 4'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With LATENCY=1 the commit happens on the accept edge, so the request is
  // taken straight from the ports instead of the not-yet-loaded latches.
  assign c_we     = (state_q == S_IDLE) ? MEM_W_EN               : we_q;
  assign c_ok     = (state_q == S_IDLE) ? w_ok                   : ok_q;
  assign c_idx    = (state_q == S_IDLE) ? w_word_idx[IDX_W-1:0]  : idx_q;
  assign c_wdata  = (state_q == S_IDLE) ? write_data             : wdata_q;
  assign w_commit = rst && (state_d == S_DONE) && (state_q != S_DONE);

  always_comb begin
    rdata_d = rdata_q;
    if (w_commit) begin
      if (!c_ok) begin
        rdata_d = 32'h0;
      end else if (c_we) begin
        rdata_d = c_wdata;
      end else begin
        rdata_d = mem_q[c_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      ok_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ok_q    <= ok_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately not reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_commit && c_we && c_ok) begin
      mem_q[c_idx] <= c_wdata;
    end
  end

  assign read_data = rdata_q;
  assign ready     = (state_q == S_DONE);
  assign freeze    = ((state_q == S_IDLE) && w_req) || (state_q == S_WAIT);

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign addr_err = (state_q == S_DONE) && !ok_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_unit.sv
`default_nettype none
// Bench for data_mem_unit: two instances (LATENCY=2 and LATENCY=1) driven with
// directed and random requests, checked against a word-array reference model.
module tb_data_mem_unit;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'd1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        r0 = 1'b0, w0 = 1'b0, r1 = 1'b0, w1 = 1'b0;
  logic [31:0] a0 = '0, d0 = '0, a1 = '0, d1 = '0;
  logic [31:0] rd0, rd1;
  logic        rdy0, rdy1, frz0, frz1, e0, e1;

  logic [31:0] mm [2][DEPTH];
  bit          mv [2][DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_unit #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst_n), .MEM_R_EN(r0), .MEM_W_EN(w0), .addr(a0),
    .write_data(d0), .read_data(rd0), .ready(rdy0), .freeze(frz0)
`ifdef DATA_MEM_ALIGN_CHECK_EN
    , .addr_err(e0)
`endif
  );

  data_mem_unit #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst_n), .MEM_R_EN(r1), .MEM_W_EN(w1), .addr(a1),
    .write_data(d1), .read_data(rd1), .ready(rdy1), .freeze(frz1)
`ifdef DATA_MEM_ALIGN_CHECK_EN
    , .addr_err(e1)
`endif
  );

`ifndef DATA_MEM_ALIGN_CHECK_EN
  assign e0 = 1'b0;
  assign e1 = 1'b0;
`endif

  // Reference model: a plain word array per instance plus written flags.
  function automatic bit m_ok(input logic [31:0] a);
    logic [31:0] off;
    off  = a - BASE;
    m_ok = (off >> 2) < 32'(DEPTH);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) m_ok = 1'b0;
`endif
  endfunction

  task automatic m_apply(input int s, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] exp, output bit known);
    int idx;
    idx   = int'((a - BASE) >> 2);
    exp   = 32'h0;
    known = 1'b1;
    if (!m_ok(a)) return;
    if (w) begin
      mm[s][idx] = d;
      mv[s][idx] = 1'b1;
      exp   = d;
      known = r;
    end else if (mv[s][idx]) begin
      exp = mm[s][idx];
    end else begin
      known = 1'b0;
    end
  endtask

  task automatic quiet();
    @(negedge clk);
    r0 = 0; w0 = 0; r1 = 0; w1 = 0;
  endtask

  // Drives one request and records what the DUT did; no checking in here.
  task automatic do_req(input int s, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble,
                        output int lat, output logic frz_t, output logic frz_w,
                        output logic frz_r, output logic [31:0] rd, output logic er,
                        output int acc);
    @(negedge clk);
    if (s == 1) begin r1 = r; w1 = w; a1 = a; d1 = d; r0 = 0; w0 = 0; end
    else        begin r0 = r; w0 = w; a0 = a; d0 = d; r1 = 0; w1 = 0; end
    #1;
    frz_t = (s == 1) ? frz1 : frz0;
    acc   = cyc;
    lat = 0; frz_w = 1'b1; frz_r = 1'b1; rd = '0; er = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk); #1;
      if (((s == 1) ? rdy1 : rdy0) === 1'b1) begin
        lat   = n;
        frz_r = (s == 1) ? frz1 : frz0;
        rd    = (s == 1) ? rd1 : rd0;
        er    = (s == 1) ? e1 : e0;
        break;
      end
      if (((s == 1) ? frz1 : frz0) !== 1'b1) frz_w = 1'b0;
      if (scramble) begin
        if (s == 1) d1 = $urandom; else d0 = $urandom;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0; r0 = 0; w0 = 0; r1 = 0; w1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL rst_ready0 got=%b want=0", rdy0); end
    checks++; if (frz0 !== 1'b0) begin failures++; $display("FAIL rst_freeze0 got=%b want=0", frz0); end
    checks++; if (rd0 !== 32'h0) begin failures++; $display("FAIL rst_rdata0 got=%h want=0", rd0); end
    checks++; if (rdy1 !== 1'b0) begin failures++; $display("FAIL rst_ready1 got=%b want=0", rdy1); end
    checks++; if (frz1 !== 1'b0) begin failures++; $display("FAIL rst_freeze1 got=%b want=0", frz1); end
    checks++; if (rd1 !== 32'h0) begin failures++; $display("FAIL rst_rdata1 got=%h want=0", rd1); end
`ifdef DATA_MEM_ALIGN_CHECK_EN
    checks++; if (e0 !== 1'b0) begin failures++; $display("FAIL rst_err0 got=%b want=0", e0); end
`endif
    rst_n = 1;
  endtask

  task automatic test_store_load();
    int lat, acc; logic ft, fw, fr, er; logic [31:0] rd, exp; bit kn;
    m_apply(0, 0, 1, 32'd1028, 32'hDEADBEEF, exp, kn);
    do_req(0, 0, 1, 32'd1028, 32'hDEADBEEF, 0, lat, ft, fw, fr, rd, er, acc);
    checks++; if (ft !== 1'b1) begin failures++; $display("FAIL sl_freeze_T got=%b want=1", ft); end
    checks++; if (fw !== 1'b1) begin failures++; $display("FAIL sl_freeze_wait got=%b want=1", fw); end
    checks++; if (lat != 2) begin failures++; $display("FAIL sl_store_lat got=%0d want=2", lat); end
    checks++; if (fr !== 1'b0) begin failures++; $display("FAIL sl_freeze_ready got=%b want=0", fr); end
    m_apply(0, 1, 0, 32'd1028, 32'h0, exp, kn);
    do_req(0, 1, 0, 32'd1028, 32'h0, 0, lat, ft, fw, fr, rd, er, acc);
    checks++; if (lat != 2) begin failures++; $display("FAIL sl_load_lat got=%0d want=2", lat); end
    checks++; if (rd !== exp) begin failures++; $display("FAIL sl_load_data got=%h want=%h", rd, exp); end
    // Request was still held during the ready cycle; it must not be re-accepted.
    quiet(); #1;
    checks++; if (frz0 !== 1'b0) begin failures++; $display("FAIL sl_no_reaccept got=%b want=0", frz0); end
  endtask

  task automatic test_back_to_back();
    int lat [3]; int acc [3]; logic ft, fw, fr, er; logic [31:0] rd, exp, v; bit kn;
    v = $urandom;
    m_apply(1, 1, 0, BASE, 32'h0, exp, kn);
    do_req(1, 1, 0, BASE, 32'h0, 0, lat[0], ft, fw, fr, rd, er, acc[0]);
    m_apply(1, 0, 1, BASE, v, exp, kn);
    do_req(1, 0, 1, BASE, v, 0, lat[1], ft, fw, fr, rd, er, acc[1]);
    m_apply(1, 1, 0, BASE, 32'h0, exp, kn);
    do_req(1, 1, 0, BASE, 32'h0, 0, lat[2], ft, fw, fr, rd, er, acc[2]);
    for (int i = 0; i < 3; i++) begin
      checks++; if (lat[i] != 1) begin failures++; $display("FAIL b2b_lat%0d got=%0d want=1", i, lat[i]); end
    end
    checks++; if (acc[1] - acc[0] != 2) begin failures++; $display("FAIL b2b_space01 got=%0d want=2", acc[1] - acc[0]); end
    checks++; if (acc[2] - acc[1] != 2) begin failures++; $display("FAIL b2b_space12 got=%0d want=2", acc[2] - acc[1]); end
    checks++; if (rd !== exp) begin failures++; $display("FAIL b2b_load got=%h want=%h", rd, exp); end
    quiet(); #1;
    checks++; if (rdy1 !== 1'b0) begin failures++; $display("FAIL b2b_no_reaccept got=%b want=0", rdy1); end
  endtask

  task automatic test_both_en();
    int lat, acc; logic ft, fw, fr, er; logic [31:0] rd, exp; bit kn;
    m_apply(0, 1, 1, 32'd1032, 32'h12345678, exp, kn);
    do_req(0, 1, 1, 32'd1032, 32'h12345678, 0, lat, ft, fw, fr, rd, er, acc);
    checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL both_rdata got=%h want=12345678", rd); end
    m_apply(0, 1, 0, 32'd1032, 32'h0, exp, kn);
    do_req(0, 1, 0, 32'd1032, 32'h0, 0, lat, ft, fw, fr, rd, er, acc);
    checks++; if (rd !== exp) begin failures++; $display("FAIL both_confirm got=%h want=%h", rd, exp); end
    quiet();
  endtask

  task automatic test_out_of_range();
    int lat, acc; logic ft, fw, fr, er; logic [31:0] rd, exp; bit kn;
    logic [31:0] addrs [4];
    bit          wr    [4];
    addrs = '{32'd0, BASE + 32'(4 * DEPTH), 32'd1026, BASE};
    wr    = '{1'b0, 1'b1, 1'b0, 1'b0};
    m_apply(0, 0, 1, BASE, 32'hA5A5_0001, exp, kn);
    do_req(0, 0, 1, BASE, 32'hA5A5_0001, 0, lat, ft, fw, fr, rd, er, acc);
    for (int i = 0; i < 4; i++) begin
      m_apply(0, !wr[i], wr[i], addrs[i], 32'hBAD0_0000 + 32'(i), exp, kn);
      do_req(0, !wr[i], wr[i], addrs[i], 32'hBAD0_0000 + 32'(i), 0, lat, ft, fw, fr, rd, er, acc);
      checks++; if (lat != 2) begin failures++; $display("FAIL oor_lat%0d got=%0d want=2", i, lat); end
      if (kn) begin
        checks++; if (rd !== exp) begin failures++; $display("FAIL oor_rdata%0d got=%h want=%h", i, rd, exp); end
      end
`ifdef DATA_MEM_ALIGN_CHECK_EN
      checks++; if (er !== !m_ok(addrs[i])) begin failures++; $display("FAIL oor_err%0d got=%b want=%b", i, er, !m_ok(addrs[i])); end
`endif
    end
    quiet();
  endtask

  task automatic test_reset_mid();
    int lat, acc; logic ft, fw, fr, er; logic [31:0] rd, exp; bit kn;
    m_apply(0, 0, 1, 32'd1036, 32'h1111_1111, exp, kn);
    do_req(0, 0, 1, 32'd1036, 32'h1111_1111, 0, lat, ft, fw, fr, rd, er, acc);
    m_apply(0, 1, 1, 32'd1040, 32'h7777_0000, exp, kn);
    do_req(0, 1, 1, 32'd1040, 32'h7777_0000, 0, lat, ft, fw, fr, rd, er, acc);
    @(negedge clk);
    r0 = 0; w0 = 1; a0 = 32'd1036; d0 = 32'hCAFEF00D;
    @(negedge clk);
    rst_n = 0; w0 = 0; #1;
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL rmid_ready got=%b want=0", rdy0); end
    checks++; if (frz0 !== 1'b0) begin failures++; $display("FAIL rmid_freeze got=%b want=0", frz0); end
    checks++; if (rd0 !== 32'h0) begin failures++; $display("FAIL rmid_rdata got=%h want=0", rd0); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); #1;
      checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL rmid_no_ready%0d got=%b want=0", n, rdy0); end
    end
    m_apply(0, 1, 0, 32'd1036, 32'h0, exp, kn);
    do_req(0, 1, 0, 32'd1036, 32'h0, 0, lat, ft, fw, fr, rd, er, acc);
    checks++; if (rd !== 32'h1111_1111) begin failures++; $display("FAIL rmid_prior got=%h want=11111111", rd); end
    quiet();
  endtask

  task automatic test_latch_hold();
    int lat, acc; logic ft, fw, fr, er; logic [31:0] rd, exp, v; bit kn;
    v = $urandom;
    m_apply(0, 0, 1, 32'd1044, v, exp, kn);
    do_req(0, 0, 1, 32'd1044, v, 1, lat, ft, fw, fr, rd, er, acc);
    m_apply(0, 1, 0, 32'd1044, 32'h0, exp, kn);
    do_req(0, 1, 0, 32'd1044, 32'h0, 0, lat, ft, fw, fr, rd, er, acc);
    checks++; if (rd !== v) begin failures++; $display("FAIL latch_data got=%h want=%h", rd, v); end
    quiet();
  endtask

  task automatic test_random();
    int lat, acc, s, k, op; logic ft, fw, fr, er; logic [31:0] rd, exp, a, d; bit kn, r, w;
    for (int i = 0; i < 120; i++) begin
      s  = int'($urandom_range(0, 1));
      k  = int'($urandom_range(0, 19));
      op = int'($urandom_range(0, 2));
      r  = (op != 1);
      w  = (op != 0);
      d  = $urandom;
      if (k < 16)       a = BASE + 32'(4 * k);
      else if (k == 16) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
      else if (k == 17) a = 32'($urandom_range(0, 1023));
      else if (k == 18) a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      else              a = BASE + 32'(4 * (DEPTH - 1));
      m_apply(s, r, w, a, d, exp, kn);
      do_req(s, r, w, a, d, 1, lat, ft, fw, fr, rd, er, acc);
      checks++; if (lat != ((s == 1) ? 1 : 2)) begin failures++; $display("FAIL rnd_lat i=%0d got=%0d want=%0d", i, lat, (s == 1) ? 1 : 2); end
      if (kn) begin
        checks++; if (rd !== exp) begin failures++; $display("FAIL rnd_rdata i=%0d a=%h got=%h want=%h", i, a, rd, exp); end
      end
`ifdef DATA_MEM_ALIGN_CHECK_EN
      checks++; if (er !== !m_ok(a)) begin failures++; $display("FAIL rnd_err i=%0d got=%b want=%b", i, er, !m_ok(a)); end
`endif
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_both_en();
    test_out_of_range();
    test_reset_mid();
    test_latch_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
